// File: rtl/pendigits_tnn_sched.sv
// Round-robin front end that time-shares one combinational pendigits classifier
// among R requesters and returns each class index tagged with its requester ID.
module pendigits_tnn_sched #(
    parameter int N      = 16,
    parameter int B      = 4,
    parameter int C      = 10,
    parameter int R      = 4,
    parameter int SETTLE = 2,
    localparam int KW    = $clog2(C),
    localparam int IW    = $clog2(R),
    localparam int SW    = N * B
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [R-1:0]      req_valid,
    input  logic [R*SW-1:0]   req_data,
    output logic [R-1:0]      req_ready,
    output logic [SW-1:0]     cls_inp,
    input  logic [KW-1:0]     cls_klass,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [IW-1:0]     resp_id,
    output logic [KW-1:0]     resp_klass,
    output logic              range_err
);
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [IW:0]   R_L    = (IW+1)'(R);
    localparam logic [IW-1:0] LAST_L = IW'(R - 1);
    localparam logic [KW:0]   C_L    = (KW+1)'(C);

    typedef enum logic [1:0] {IDLE, EVAL, RESP} state_t;

    state_t        state;
    logic [IW-1:0] ptr;
    logic [IW-1:0] id;
    logic [CW-1:0] cnt;
    logic [IW-1:0] sel;
    logic          any;
    logic [IW:0]   sum;

    function automatic logic klass_oor(input logic [KW-1:0] k);
        return {1'b0, k} >= C_L;
    endfunction

    function automatic logic [IW-1:0] next_id(input logic [IW-1:0] i);
        return (i == LAST_L) ? '0 : i + IW'(1);
    endfunction

    // Scan from the farthest offset down so the offset nearest ptr wins.
    always_comb begin
        sel = '0;
        any = 1'b0;
        sum = '0;
        for (int k = R - 1; k >= 0; k--) begin
            sum = {1'b0, ptr} + (IW+1)'(k);
            if (sum >= R_L) sum = sum - R_L;
            if (req_valid[sum[IW-1:0]]) begin
                sel = sum[IW-1:0];
                any = 1'b1;
            end
        end
    end

    assign req_ready = (state == IDLE && any && !rst) ? (R'(1) << sel) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= '0;
            id         <= '0;
            cnt        <= '0;
            cls_inp    <= '0;
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_klass <= '0;
            range_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any) begin
                        cls_inp <= req_data[sel*SW +: SW];
                        id      <= sel;
                        cnt     <= CW'(SETTLE - 1);
                        state   <= EVAL;
                    end
                end
                EVAL: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        resp_klass <= cls_klass;
                        resp_id    <= id;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                        if (klass_oor(cls_klass)) range_err <= 1'b1;
                    end
                end
                RESP: begin
                    // Advancing ptr past the served ID gives it lowest priority next.
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        ptr        <= next_id(id);
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pendigits_tnn_sched.sv
// Directed bench for pendigits_tnn_sched with a stub classifier klass = inp[3:0].
module tb_pendigits_tnn_sched;
    localparam int N = 16, B = 4, C = 10, R = 4, SETTLE = 2;
    localparam int KW = 4, IW = 2, SW = 64;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [R-1:0]    req_valid = '0;
    logic [R*SW-1:0] req_data = '0;
    logic [R-1:0]    req_ready;
    logic [SW-1:0]   cls_inp;
    logic [KW-1:0]   cls_klass;
    logic            resp_valid;
    logic            resp_ready = 1'b1;
    logic [IW-1:0]   resp_id;
    logic [KW-1:0]   resp_klass;
    logic            range_err;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    pendigits_tnn_sched #(.N(N), .B(B), .C(C), .R(R), .SETTLE(SETTLE)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .cls_inp(cls_inp), .cls_klass(cls_klass),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_klass(resp_klass), .range_err(range_err)
    );

    assign cls_klass = cls_inp[3:0];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic wait_resp(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (resp_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        req_valid = 4'b1111;
        @(negedge clk);
        checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", resp_valid); end
        checks++; if (cls_inp !== 64'h0) begin failures++; $display("FAIL reset_inp got=%h exp=0", cls_inp); end
        checks++; if (resp_id !== 2'd0 || resp_klass !== 4'd0) begin failures++; $display("FAIL reset_resp got id=%0d klass=%0d exp 0/0", resp_id, resp_klass); end
        checks++; if (range_err !== 1'b0) begin failures++; $display("FAIL reset_rerr got=%b exp=0", range_err); end
        req_valid = '0;
    endtask

    task automatic test_single();
        do_reset();
        req_data[0 +: SW] = 64'h0e4f7c572260b0f1;
        req_valid = 4'b0001;
        #1;
        checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL single_ready got=%b exp=0001", req_ready); end
        @(negedge clk);
        req_valid = '0;
        checks++; if (cls_inp !== 64'h0e4f7c572260b0f1) begin failures++; $display("FAIL single_inp got=%h exp=0e4f7c572260b0f1", cls_inp); end
        checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL single_early1 got=%b exp=0", resp_valid); end
        @(negedge clk);
        checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL single_early2 got=%b exp=0", resp_valid); end
        @(negedge clk);
        checks++; if (resp_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", resp_valid); end
        checks++; if (resp_id !== 2'd0 || resp_klass !== 4'd1) begin failures++; $display("FAIL single_resp got id=%0d klass=%0d exp 0/1", resp_id, resp_klass); end
        checks++; if (range_err !== 1'b0) begin failures++; $display("FAIL single_rerr got=%b exp=0", range_err); end
        @(negedge clk);
        checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL single_done got=%b exp=0", resp_valid); end
    endtask

    task automatic test_round_robin();
        int exp_id [5] = '{0, 1, 2, 3, 0};
        int t_prev = 0;
        bit ok;
        do_reset();
        for (int i = 0; i < R; i++) req_data[i*SW +: SW] = {60'h5a5a_1234_9876_c3c, 4'(i)};
        req_valid = 4'b1111;
        resp_ready = 1'b1;
        for (int j = 0; j < 5; j++) begin
            wait_resp(ok);
            if (j == 4) req_valid = '0;
            checks++; if (!ok) begin failures++; $display("FAIL rr_timeout job=%0d got=no_resp exp=resp", j); end
            checks++; if (resp_id !== 2'(exp_id[j]) || resp_klass !== 4'(exp_id[j])) begin
                failures++; $display("FAIL rr_resp job=%0d got id=%0d klass=%0d exp=%0d", j, resp_id, resp_klass, exp_id[j]);
            end
            if (j > 0) begin
                checks++; if (cyc - t_prev != SETTLE + 2) begin failures++; $display("FAIL rr_spacing job=%0d got=%0d exp=%0d", j, cyc - t_prev, SETTLE + 2); end
            end
            t_prev = cyc;
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        bit ok;
        req_data[2*SW +: SW] = 64'hdead_beef_0123_4565;
        req_valid = 4'b0100;
        resp_ready = 1'b0;
        wait_resp(ok);
        checks++; if (!ok) begin failures++; $display("FAIL bp_timeout got=no_resp exp=resp"); end
        req_valid = 4'b1111;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++; if (resp_valid !== 1'b1 || resp_id !== 2'd2 || resp_klass !== 4'd5 || req_ready !== 4'b0000) begin
                failures++; $display("FAIL bp_hold cyc=%0d got v=%b id=%0d k=%0d rdy=%b exp 1/2/5/0000", i, resp_valid, resp_id, resp_klass, req_ready);
            end
        end
        req_valid = '0;
        resp_ready = 1'b1;
        @(negedge clk);
        checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL bp_release got=%b exp=0", resp_valid); end
        req_valid = 4'b0001;
        #1;
        checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL bp_idle got=%b exp=0001", req_ready); end
        req_valid = '0;
    endtask

    task automatic test_range_err();
        bit ok;
        @(negedge clk);
        req_data[0 +: SW] = 64'h8f4d96400498fe6f;
        req_valid = 4'b0001;
        wait_resp(ok);
        req_valid = '0;
        checks++; if (!ok || resp_klass !== 4'hF || range_err !== 1'b1) begin
            failures++; $display("FAIL rerr_set got ok=%b klass=%h rerr=%b exp 1/f/1", ok, resp_klass, range_err);
        end
        @(negedge clk);
        req_data[1*SW +: SW] = 64'h1111_2222_3333_4443;
        req_valid = 4'b0010;
        wait_resp(ok);
        req_valid = '0;
        checks++; if (!ok || resp_id !== 2'd1 || resp_klass !== 4'd3 || range_err !== 1'b1) begin
            failures++; $display("FAIL rerr_sticky got ok=%b id=%0d klass=%0d rerr=%b exp 1/1/3/1", ok, resp_id, resp_klass, range_err);
        end
        do_reset();
        checks++; if (range_err !== 1'b0) begin failures++; $display("FAIL rerr_clear got=%b exp=0", range_err); end
    endtask

    task automatic test_mid_reset();
        bit ok;
        req_data[1*SW +: SW] = 64'h0abc_0000_ffff_0007;
        req_data[3*SW +: SW] = 64'h7777_6666_5555_4449;
        req_valid = 4'b1000;
        @(negedge clk);
        rst = 1'b1;
        req_valid = 4'b1010;
        #1;
        checks++; if (resp_valid !== 1'b0 || cls_inp !== 64'h0 || req_ready !== 4'b0000) begin
            failures++; $display("FAIL midrst_hold got v=%b inp=%h rdy=%b exp 0/0/0000", resp_valid, cls_inp, req_ready);
        end
        @(negedge clk);
        checks++; if (resp_valid !== 1'b0 || req_ready !== 4'b0000) begin
            failures++; $display("FAIL midrst_hold2 got v=%b rdy=%b exp 0/0000", resp_valid, req_ready);
        end
        rst = 1'b0;
        #1;
        checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL midrst_grant got=%b exp=0010", req_ready); end
        @(negedge clk);
        req_valid = '0;
        wait_resp(ok);
        checks++; if (!ok || resp_id !== 2'd1 || resp_klass !== 4'd7) begin
            failures++; $display("FAIL midrst_resp got ok=%b id=%0d klass=%0d exp 1/1/7", ok, resp_id, resp_klass);
        end
        @(negedge clk);
    endtask

    task automatic test_withdrawn();
        bit ok;
        req_data[0 +: SW] = 64'h0000_1111_2222_3338;
        req_data[2*SW +: SW] = 64'hffff_eeee_dddd_ccc4;
        req_data[3*SW +: SW] = 64'h1234_5678_9abc_def6;
        req_valid = 4'b0001;
        @(negedge clk);
        req_valid = 4'b0100;
        @(negedge clk);
        req_valid = '0;
        wait_resp(ok);
        checks++; if (!ok || resp_id !== 2'd0 || resp_klass !== 4'd8) begin
            failures++; $display("FAIL wd_resp got ok=%b id=%0d klass=%0d exp 1/0/8", ok, resp_id, resp_klass);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++; if (resp_valid !== 1'b0 || cls_inp !== 64'h0000_1111_2222_3338) begin
                failures++; $display("FAIL wd_quiet cyc=%0d got v=%b inp=%h exp 0/0000111122223338", i, resp_valid, cls_inp);
            end
        end
        req_valid = 4'b1000;
        wait_resp(ok);
        req_valid = '0;
        checks++; if (!ok || resp_id !== 2'd3 || resp_klass !== 4'd6) begin
            failures++; $display("FAIL wd_next got ok=%b id=%0d klass=%0d exp 1/3/6", ok, resp_id, resp_klass);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_range_err();
        test_mid_reset();
        test_withdrawn();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pendigits_tnn_sched.md
# pendigits_tnn_sched

Round-robin scheduler that shares one combinational pendigits ternary classifier among R requesters. It accepts one feature vector at a time and drives it onto the classifier input. It then waits a fixed settle interval for the combinational logic to resolve, captures the class index, and returns it with the requester ID over a valid/ready response channel. It sits between the sample sources and the classifier instance, and is the only driver of the classifier input.

## Interface
- N, 16, features per sample
- B, 4, bits per feature; sample width is N*B
- C, 10, number of classes; class index width KW = $clog2(C)
- R, 4, number of requesters (R >= 2); ID width IW = $clog2(R)
- SETTLE, 2, cycles the classifier input is held before klass is sampled (SETTLE >= 1)

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  R  per-requester request
- req_data  in  R*N*B  per-requester sample; slice i is [i*N*B +: N*B]
- req_ready  out  R  one-hot accept, combinational
- cls_inp  out  N*B  registered sample to the classifier's inp
- cls_klass  in  KW  classifier's klass output
- resp_valid  out  1  result available
- resp_ready  in  1  consumer accepts result
- resp_id  out  IW  index of the requester that owns the result
- resp_klass  out  KW  captured class index
- range_err  out  1  sticky flag: a captured klass was >= C

## Operation
- States are IDLE, EVAL and RESP. Reset enters IDLE.
- IDLE behaviour:
  - sel is the first i with req_valid[i] set, scanning ptr, ptr+1, …, wrapping modulo R.
  - req_ready[sel] = 1; all other bits are 0. req_ready is all-zero outside IDLE and while rst is high.
  - On req_valid[sel] & req_ready[sel] at an edge:
    - cls_inp <= slice sel of req_data
    - id <= sel
    - cnt <= SETTLE-1
    - state -> EVAL
- EVAL behaviour:
  - cls_inp is held constant.
  - If cnt != 0: cnt decrements.
  - If cnt == 0: resp_klass <= cls_klass, resp_id <= id, resp_valid <= 1, state -> RESP. If cls_klass >= C, range_err <= 1.
- RESP behaviour:
  - resp_valid, resp_id and resp_klass are held stable.
  - On resp_valid & resp_ready: resp_valid <= 0, ptr <= (id+1) mod R, state -> IDLE.
- Arbitration is round-robin. ptr advances only when a response completes, so the most recently served requester has lowest priority next time.
- Requester rules:
  - A requester holds req_data stable while req_valid is high and it is not yet accepted.
  - Dropping req_valid before acceptance is legal and has no effect.
  - req_valid in EVAL or RESP is ignored and is not queued.
- cls_inp retains the last accepted sample after the job completes. It is not cleared.
- range_err is cleared only by rst. When C is a power of two, range_err is constant 0.
- ptr wraps from R-1 to 0. Arithmetic is modulo R; for non-power-of-two R, compare against R-1 explicitly.

## Timing
- Reset values: state IDLE, ptr 0, cnt 0, cls_inp 0, resp_valid 0, resp_id 0, resp_klass 0, range_err 0, req_ready all-zero.
- Reset asserted mid-job aborts the job, with no response and no req_ready. After release, arbitration restarts from ptr 0.
- Latency:
  - Accept edge k: cls_inp is valid after edge k.
  - klass is sampled at edge k+SETTLE.
  - resp_valid is high in the cycle after edge k+SETTLE.
- Throughput: minimum SETTLE+2 cycles per job with resp_ready tied high (accept cycle, SETTLE-cycle EVAL, one RESP cycle). The IDLE cycle follows, and the next accept can occur in it.
- With SETTLE=1, EVAL lasts exactly one cycle.
- resp_ready held low stalls the block in RESP indefinitely. Outputs stay stable and no new request is accepted.
- Simultaneous requests in IDLE: exactly one is granted per job, selected by round-robin.

## Test plan
Use a stub classifier: cls_klass = cls_inp[3:0] (combinational). SETTLE=2, R=4.

- Single request: rst pulse, then req_valid=4'b0001 with slice0=64'h0e4f7c572260b0f1. Required: req_ready=4'b0001 in the first IDLE cycle; resp_valid rises 2 cycles after accept; resp_id=0, resp_klass=1, range_err=0.
- Round-robin: all four req_valid high, slices ending in nibbles 0,1,2,3, resp_ready=1. Required: resp_id sequence 0,1,2,3,0; resp_klass equal to the id; each job spaced SETTLE+2 cycles.
- Backpressure: resp_ready=0 for 10 cycles after resp_valid rises. Required: resp_id, resp_klass and resp_valid are stable; req_ready stays all-zero; release gives a one-cycle handshake, then a return to IDLE.
- Range error: slice 64'h8f4d96400498fe6f, whose low nibble is 15. Required: resp_klass=4'hF and range_err=1, still 1 after a later job with klass 3, cleared only by rst.
- Mid-job reset: assert rst one cycle into EVAL. Required: resp_valid=0, cls_inp=0, req_ready=0 during reset; after release, a pending req_valid=4'b1010 is granted to requester 1 (ptr restarted at 0).
- Withdrawn request: req_valid[2] pulses for one cycle while in EVAL. Required: no job is ever issued for requester 2, and the other responses are unaffected.
